// File: rtl/fp2_addsub_arbiter.sv
// Two-requester round-robin arbiter in front of a shared GF(p)/GF(p^2) add/sub unit.
// Optional watchdog on the unit's done pulse: define FP2_ARB_WATCHDOG_EN.
module fp2_addsub_arbiter #(
   parameter int RADIX      = 32,
   parameter int DIGITS     = 14,
   parameter int DIGITS_LOG = $clog2(DIGITS),
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic [2:0]            cmd0,
   input  logic                  ext0,
   output logic                  grant0,
   output logic                  done0,
   output logic                  err0,
   input  logic                  rd0_en,
   input  logic [DIGITS_LOG-1:0] rd0_addr,
   output logic [RADIX-1:0]      c00_dout,
   output logic [RADIX-1:0]      c10_dout,
   input  logic                  req1,
   input  logic [2:0]            cmd1,
   input  logic                  ext1,
   output logic                  grant1,
   output logic                  done1,
   output logic                  err1,
   input  logic                  rd1_en,
   input  logic [DIGITS_LOG-1:0] rd1_addr,
   output logic [RADIX-1:0]      c01_dout,
   output logic [RADIX-1:0]      c11_dout,
   output logic                  u_start,
   output logic [2:0]            u_cmd,
   output logic                  u_ext,
   input  logic                  u_done,
   output logic                  u_c0_rd_en,
   output logic [DIGITS_LOG-1:0] u_c0_rd_addr,
   output logic                  u_c1_rd_en,
   output logic [DIGITS_LOG-1:0] u_c1_rd_addr,
   input  logic [RADIX-1:0]      u_c0_dout,
   input  logic [RADIX-1:0]      u_c1_dout
);

   typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

   state_t state;
   logic   ptr;
   logic   sel1;
   logic   cmd_ok;
   logic   hold;
   logic   own_req;

   // ptr names the winner only when both requesters are asking
   assign sel1    = req1 && (!req0 || ptr);
   assign cmd_ok  = (u_cmd != 3'd0) && (u_cmd <= 3'd5);
   assign hold    = (state == HOLD);
   assign own_req = grant1 ? req1 : req0;

`ifdef FP2_ARB_WATCHDOG_EN
   localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   logic [WD_W-1:0] wd_cnt;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= 1'b0;
         grant0  <= 1'b0;
         grant1  <= 1'b0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         err0    <= 1'b0;
         err1    <= 1'b0;
         u_start <= 1'b0;
         u_cmd   <= 3'd0;
         u_ext   <= 1'b0;
`ifdef FP2_ARB_WATCHDOG_EN
         wd_cnt  <= '0;
`endif
      end else begin
         done0   <= 1'b0;
         done1   <= 1'b0;
         err0    <= 1'b0;
         err1    <= 1'b0;
         u_start <= 1'b0;
         case (state)
            IDLE: if (req0 || req1) begin
               grant0 <= !sel1;
               grant1 <= sel1;
               u_cmd  <= sel1 ? cmd1 : cmd0;
               u_ext  <= sel1 ? ext1 : ext0;
               state  <= START;
            end
            START: if (cmd_ok) begin
               u_start <= 1'b1;
               state   <= WAIT;
`ifdef FP2_ARB_WATCHDOG_EN
               wd_cnt  <= '0;
`endif
            end else begin
               done0 <= grant0;
               done1 <= grant1;
               err0  <= grant0;
               err1  <= grant1;
               state <= HOLD;
            end
            WAIT: begin
               // u_done wins over a watchdog expiry in the same cycle
               if (u_done) begin
                  done0 <= grant0;
                  done1 <= grant1;
                  state <= HOLD;
               end
`ifdef FP2_ARB_WATCHDOG_EN
               else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                  done0 <= grant0;
                  done1 <= grant1;
                  err0  <= grant0;
                  err1  <= grant1;
                  state <= HOLD;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
`endif
            end
            HOLD: if (!own_req) begin
               ptr    <= grant0;
               grant0 <= 1'b0;
               grant1 <= 1'b0;
               u_cmd  <= 3'd0;
               u_ext  <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Result read-back: only the owner's port reaches the unit, only in HOLD
   assign u_c0_rd_en   = hold && (grant1 ? rd1_en : rd0_en);
   assign u_c1_rd_en   = u_c0_rd_en;
   assign u_c0_rd_addr = hold ? (grant1 ? rd1_addr : rd0_addr) : '0;
   assign u_c1_rd_addr = u_c0_rd_addr;
   assign c00_dout     = (hold && grant0) ? u_c0_dout : '0;
   assign c10_dout     = (hold && grant0) ? u_c1_dout : '0;
   assign c01_dout     = (hold && grant1) ? u_c0_dout : '0;
   assign c11_dout     = (hold && grant1) ? u_c1_dout : '0;

endmodule

// File: tb/tb_fp2_addsub_arbiter.sv
// Directed bench for fp2_addsub_arbiter: table of single-requester transactions plus
// hand sequences for arbitration, read-back, watchdog and mid-operation reset.
module tb_fp2_addsub_arbiter;
   localparam int RADIX = 32;
   localparam int DL    = 4;

   logic clk, rst_n;
   logic req0, ext0, rd0_en, req1, ext1, rd1_en;
   logic [2:0] cmd0, cmd1;
   logic [DL-1:0] rd0_addr, rd1_addr;
   logic grant0, done0, err0, grant1, done1, err1;
   logic [RADIX-1:0] c00_dout, c10_dout, c01_dout, c11_dout;
   logic u_start, u_ext, u_done, u_c0_rd_en, u_c1_rd_en;
   logic [2:0] u_cmd;
   logic [DL-1:0] u_c0_rd_addr, u_c1_rd_addr;
   logic [RADIX-1:0] u_c0_dout, u_c1_dout;

   int tests = 0;
   int fails = 0;

   fp2_addsub_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .cmd0(cmd0), .ext0(ext0), .grant0(grant0), .done0(done0), .err0(err0),
      .rd0_en(rd0_en), .rd0_addr(rd0_addr), .c00_dout(c00_dout), .c10_dout(c10_dout),
      .req1(req1), .cmd1(cmd1), .ext1(ext1), .grant1(grant1), .done1(done1), .err1(err1),
      .rd1_en(rd1_en), .rd1_addr(rd1_addr), .c01_dout(c01_dout), .c11_dout(c11_dout),
      .u_start(u_start), .u_cmd(u_cmd), .u_ext(u_ext), .u_done(u_done),
      .u_c0_rd_en(u_c0_rd_en), .u_c0_rd_addr(u_c0_rd_addr),
      .u_c1_rd_en(u_c1_rd_en), .u_c1_rd_addr(u_c1_rd_addr),
      .u_c0_dout(u_c0_dout), .u_c1_dout(u_c1_dout)
   );

   // unit memory model: data is a tag plus the address
   assign u_c0_dout = 32'hA5A5_0000 + {28'd0, u_c0_rd_addr};
   assign u_c1_dout = 32'h5A5A_0000 + {28'd0, u_c1_rd_addr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   typedef struct {
      bit       id;
      bit [2:0] cmd;
      bit       ext;
      int       delay;
      bit       exp_err;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_grant"}, {grant1, grant0}, 0);
      chk({nm, "_done_err"}, {done1, done0, err1, err0}, 0);
      chk({nm, "_unit"}, {u_start, u_cmd, u_ext}, 0);
      chk({nm, "_rd"}, {u_c0_rd_en, u_c1_rd_en, u_c0_rd_addr, u_c1_rd_addr}, 0);
      chk({nm, "_dout"}, {c00_dout, c10_dout}, 0);
      chk({nm, "_dout1"}, {c01_dout, c11_dout}, 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk_all_zero("reset");
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic run_vec(input vec_t v);
      logic [1:0] m;
      m = v.id ? 2'b10 : 2'b01;
      if (v.id) begin req1 = 1; cmd1 = v.cmd; ext1 = v.ext; end
      else      begin req0 = 1; cmd0 = v.cmd; ext0 = v.ext; end
      step();
      chk("grant", {grant1, grant0}, m);
      chk("start_early", u_start, 0);
      step();
      if (v.exp_err) begin
         chk("ill_start", u_start, 0);
         chk("ill_done", {done1, done0}, m);
         chk("ill_err", {err1, err0}, m);
      end else begin
         chk("u_start", u_start, 1);
         chk("u_cmd", u_cmd, v.cmd);
         chk("u_ext", u_ext, v.ext);
         step();
         chk("start_pulse", u_start, 0);
         repeat (v.delay) step();
         chk("early_done", {done1, done0}, 0);
         u_done = 1;
         step();
         u_done = 0;
         chk("done", {done1, done0}, m);
         chk("err_clear", {err1, err0}, 0);
      end
      step();
      chk("done_pulse", {done1, done0, err1, err0}, 0);
      chk("grant_hold", {grant1, grant0}, m);
      u_done = 1;
      step();
      u_done = 0;
      chk("stray_u_done", {done1, done0}, 0);
      req0 = 0; req1 = 0;
      step();
      chk("release", {grant1, grant0}, 0);
      step();
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{id: 0, cmd: 3'd1, ext: 1, delay: 0, exp_err: 0};
      vecs[1] = '{id: 1, cmd: 3'd2, ext: 0, delay: 3, exp_err: 0};
      vecs[2] = '{id: 0, cmd: 3'd5, ext: 1, delay: 1, exp_err: 0};
      vecs[3] = '{id: 1, cmd: 3'd7, ext: 0, delay: 0, exp_err: 1};
      vecs[4] = '{id: 0, cmd: 3'd0, ext: 1, delay: 0, exp_err: 1};
      vecs[5] = '{id: 1, cmd: 3'd6, ext: 1, delay: 0, exp_err: 1};
      vecs[6] = '{id: 0, cmd: 3'd3, ext: 0, delay: 5, exp_err: 0};
      vecs[7] = '{id: 1, cmd: 3'd4, ext: 1, delay: 2, exp_err: 0};

      rst_n = 0; req0 = 0; req1 = 0; cmd0 = 0; cmd1 = 0; ext0 = 0; ext1 = 0;
      rd0_en = 0; rd1_en = 0; rd0_addr = 0; rd1_addr = 0; u_done = 0;
      #3;
      do_reset();

      foreach (vecs[i]) run_vec(vecs[i]);

      // simultaneous requests after reset: 0 first, then 1, then 0 again
      do_reset();
      req0 = 1; req1 = 1; cmd0 = 3'd1; cmd1 = 3'd2; ext0 = 0; ext1 = 1;
      step();
      chk("arb_first", {grant1, grant0}, 2'b01);
      step();
      chk("arb_cmd0", u_cmd, 3'd1);
      u_done = 1; step(); u_done = 0;
      chk("arb_done0", done0, 1);
      req0 = 0;
      step();
      chk("arb_rel0", {grant1, grant0}, 2'b00);
      step();
      chk("arb_second", {grant1, grant0}, 2'b10);
      step();
      chk("arb_cmd1", {u_start, u_cmd, u_ext}, {1'b1, 3'd2, 1'b1});
      req1 = 0;  // dropped before HOLD: must still complete
      step();
      u_done = 1; step(); u_done = 0;
      chk("early_drop_done", {done1, grant1}, 2'b11);
      step();
      chk("early_drop_rel", {grant1, grant0}, 2'b00);
      step();
      req0 = 1; req1 = 1;
      step();
      chk("arb_rr_back", {grant1, grant0}, 2'b01);

      // reset mid-WAIT discards the operation
      step(); step();
      chk("rst_in_wait", {grant0, u_start}, 2'b10);
      rst_n = 0; req0 = 0; req1 = 0;
      #1;
      chk_all_zero("rst_mid");
      step();
      rst_n = 1;
      u_done = 1; step(); u_done = 0;
      chk("rst_no_done", {done1, done0, grant1, grant0}, 0);
      step();
      chk("rst_idle", {done1, done0, grant1, grant0}, 0);

      // read-back in HOLD with grant0
      req0 = 1; cmd0 = 3'd1; ext0 = 0;
      step(); step(); step();
      u_done = 1; step(); u_done = 0;
      rd0_en = 1; rd0_addr = 4'd13; rd1_en = 1; rd1_addr = 4'd3;
      #1;
      chk("rb_addr", {u_c0_rd_addr, u_c1_rd_addr}, {4'd13, 4'd13});
      chk("rb_en", {u_c0_rd_en, u_c1_rd_en}, 2'b11);
      chk("rb_c00", c00_dout, 32'hA5A5_000D);
      chk("rb_c10", c10_dout, 32'h5A5A_000D);
      chk("rb_c01", {c01_dout, c11_dout}, 0);
      rd0_en = 0;
      #1;
      chk("rb_rd1_ignored", {u_c0_rd_en, u_c1_rd_en}, 2'b00);
      rd0_en = 1; req0 = 0;
      step();
      chk("rb_released", {u_c0_rd_en, u_c0_rd_addr, c00_dout}, 0);
      rd0_en = 0; rd1_en = 0; rd0_addr = 0; rd1_addr = 0;
      step();

`ifdef FP2_ARB_WATCHDOG_EN
      req0 = 1; cmd0 = 3'd2;
      step(); step();
      chk("wd_start", u_start, 1);
      repeat (254) step();
      chk("wd_not_yet", {done0, err0}, 2'b00);
      step();
      chk("wd_expire", {done0, err0}, 2'b11);
      req0 = 0; step(); step();
      req0 = 1;
      step(); step();
      repeat (254) step();
      u_done = 1; step(); u_done = 0;
      chk("wd_tie_success", {done0, err0}, 2'b10);
      req0 = 0; step(); step();
`else
      req0 = 1; cmd0 = 3'd2;
      step(); step();
      chk("nowd_start", u_start, 1);
      repeat (1000) step();
      chk("nowd_waiting", {grant0, done0, err0}, 3'b100);
      u_done = 1; step(); u_done = 0;
      chk("nowd_done", {done0, err0}, 2'b10);
      req0 = 0; step(); step();
`endif
      chk("final_idle", {grant1, grant0}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
